// File: rtl/nanosoc_bootrom_prefetch_0.sv
// Single-line read prefetch buffer in front of the nanosoc bootrom region.
// Read misses fill the whole line sequentially from word 0; hits return with zero wait states.
module nanosoc_bootrom_prefetch_0 #(
  parameter int SYS_ADDR_W   = 32,
  parameter int SYS_DATA_W   = 32,
  parameter int LINE_WORDS_W = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  S_HSEL,
  input  logic [SYS_ADDR_W-1:0] S_HADDR,
  input  logic [1:0]            S_HTRANS,
  input  logic [2:0]            S_HSIZE,
  input  logic [3:0]            S_HPROT,
  input  logic                  S_HWRITE,
  input  logic                  S_HREADY,
  input  logic [SYS_DATA_W-1:0] S_HWDATA,
  output logic                  S_HREADYOUT,
  output logic                  S_HRESP,
  output logic [SYS_DATA_W-1:0] S_HRDATA,
  output logic                  M_HSEL,
  output logic [SYS_ADDR_W-1:0] M_HADDR,
  output logic [1:0]            M_HTRANS,
  output logic [2:0]            M_HSIZE,
  output logic [3:0]            M_HPROT,
  output logic                  M_HWRITE,
  output logic [SYS_DATA_W-1:0] M_HWDATA,
  input  logic                  M_HREADY,
  input  logic                  M_HRESP,
  input  logic [SYS_DATA_W-1:0] M_HRDATA,
  input  logic                  INVALIDATE
);
  localparam int LW = LINE_WORDS_W;
  localparam int TW = SYS_ADDR_W - LW - 2;
  localparam int NW = 1 << LW;

  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_RESP, ST_ERR1, ST_ERR2} state_t;
  state_t state;

  logic [SYS_DATA_W-1:0] line_mem [NW];
  logic [TW-1:0] tag, req_tag, a_tag;
  logic [LW-1:0] req_idx, a_idx, acnt, acnt_nxt, dcnt;
  logic          valid, inv_pend, dphase;
  logic          ready_st, accept, hit, m_err, cap, last;

  assign M_HSIZE  = 3'b010;
  assign M_HWRITE = 1'b0;
  assign M_HWDATA = '0;

  logic unused;
  assign unused = ^{S_HSIZE, S_HWDATA, S_HADDR[1:0]};

  assign a_tag    = S_HADDR[SYS_ADDR_W-1:LW+2];
  assign a_idx    = S_HADDR[LW+1:2];
  assign ready_st = (state == ST_IDLE) || (state == ST_RESP) || (state == ST_ERR2);
  assign accept   = ready_st && S_HSEL && S_HREADY && S_HTRANS[1];
  assign hit      = valid && (tag == a_tag);
  assign acnt_nxt = acnt + LW'(1);
  assign m_err    = dphase && M_HRESP;
  assign cap      = dphase && M_HREADY && !M_HRESP;
  assign last     = (dcnt == '1);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      valid       <= 1'b0;
      inv_pend    <= 1'b0;
      dphase      <= 1'b0;
      acnt        <= '0;
      dcnt        <= '0;
      tag         <= '0;
      req_tag     <= '0;
      req_idx     <= '0;
      S_HREADYOUT <= 1'b1;
      S_HRESP     <= 1'b0;
      S_HRDATA    <= '0;
      M_HSEL      <= 1'b0;
      M_HTRANS    <= 2'b00;
      M_HADDR     <= '0;
      M_HPROT     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP, ST_ERR2: begin
          state       <= ST_IDLE;
          S_HREADYOUT <= 1'b1;
          S_HRESP     <= 1'b0;
          if (INVALIDATE) valid <= 1'b0;
          if (accept) begin
            req_tag <= a_tag;
            req_idx <= a_idx;
            if (S_HWRITE) begin
              state       <= ST_ERR1;
              S_HREADYOUT <= 1'b0;
              S_HRESP     <= 1'b1;
            end else if (hit) begin
              // Uses the pre-invalidate line, so a coincident INVALIDATE still serves this hit.
              S_HRDATA <= line_mem[a_idx];
            end else begin
              state       <= ST_FILL;
              S_HREADYOUT <= 1'b0;
              valid       <= 1'b0;
              inv_pend    <= INVALIDATE;
              acnt        <= '0;
              dcnt        <= '0;
              dphase      <= 1'b0;
              M_HSEL      <= 1'b1;
              M_HTRANS    <= 2'b10;
              M_HADDR     <= {a_tag, {LW{1'b0}}, 2'b00};
              M_HPROT     <= S_HPROT;
            end
          end
        end

        ST_FILL: begin
          if (INVALIDATE) inv_pend <= 1'b1;
          if (m_err) begin
            // First error cycle drops the bus to IDLE; the completing cycle moves upstream to ERROR.
            valid    <= 1'b0;
            M_HSEL   <= 1'b0;
            M_HTRANS <= 2'b00;
            if (M_HREADY) begin
              state   <= ST_ERR1;
              S_HRESP <= 1'b1;
              dphase  <= 1'b0;
            end
          end else begin
            if (cap) begin
              line_mem[dcnt] <= M_HRDATA;
              dcnt           <= dcnt + LW'(1);
              if (last) begin
                state       <= ST_RESP;
                S_HREADYOUT <= 1'b1;
                valid       <= !(inv_pend || INVALIDATE);
                tag         <= req_tag;
                S_HRDATA    <= (req_idx == dcnt) ? M_HRDATA : line_mem[req_idx];
              end
            end
            if (M_HREADY) begin
              dphase <= (M_HTRANS != 2'b00);
              if (M_HTRANS != 2'b00) begin
                if (acnt == '1) begin
                  M_HSEL   <= 1'b0;
                  M_HTRANS <= 2'b00;
                end else begin
                  acnt     <= acnt_nxt;
                  M_HTRANS <= 2'b11;
                  M_HADDR  <= {req_tag, acnt_nxt, 2'b00};
                end
              end
            end
          end
        end

        ST_ERR1: begin
          state       <= ST_ERR2;
          S_HREADYOUT <= 1'b1;
          S_HRESP     <= 1'b1;
          if (INVALIDATE) valid <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
